// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: TX command headers,
// requester indices and a small strobe-routing helper.
package mem_port_arbiter_pkg;

   localparam int TX_CMD_BITS = 4;

   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 4'h1;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'h2;

   localparam logic REQ_PF = 1'b0;
   localparam logic REQ_SC = 1'b1;

   // Steer a single strobe onto the requester selected by sel; the other reads 0.
   function automatic logic [1:0] route(input logic sel, input logic strobe);
      return {sel & strobe, ~sel & strobe};
   endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_tag_fifo.sv
// Ordered queue of 1-bit owner tags, one per outstanding read reply.
// Circular buffer with pointers wrapping modulo DEPTH (DEPTH in 1..15).
module owner_tag_fifo #(
   parameter int DEPTH = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       din,
   output logic       head,
   output logic [3:0] count,
   output logic       empty,
   output logic       full
);

   logic [15:0] mem_q;
   logic [3:0]  rd_q, wr_q, count_q;
   logic        do_push, do_pop;

   function automatic logic [3:0] wrap_inc(input logic [3:0] p);
      return (p == 4'(DEPTH - 1)) ? 4'd0 : p + 4'd1;
   endfunction

   assign empty = (count_q == 4'd0);
   assign full  = (count_q == 4'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_q];

   // Pops on an empty queue are ignored; a push into a full queue is only
   // taken when the same cycle frees a slot.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer, occupancy and storage update.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din;
            wr_q        <= wrap_inc(wr_q);
         end
         if (do_pop) rd_q <= wrap_inc(rd_q);
         if (do_push && !do_pop)      count_q <= count_q + 4'd1;
         else if (do_pop && !do_push) count_q <= count_q - 4'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one serial memory_interface between the prefetcher (0) and the
// scheduler/decoder (1). The TX grant is held for a whole transaction and
// read replies are steered back to their issuer through an owner-tag queue.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int                   IO_BITS         = 2,
   parameter int                   CMD_BITS        = TX_CMD_BITS,
   parameter logic [CMD_BITS-1:0]  READ_CMD        = TX_HEADER_READ_16,
   parameter int                   MAX_OUTSTANDING = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   input  logic [2*CMD_BITS-1:0] req_cmd,
   input  logic [2*IO_BITS-1:0]  req_data,
   input  logic [1:0]            req_reply_wanted,
   input  logic                  sc_reserve,
   output logic [1:0]            req_started,
   output logic [1:0]            req_tx_active,
   output logic [1:0]            req_data_next,
   output logic [1:0]            req_tx_done,
   output logic [1:0]            req_rx_started,
   output logic [1:0]            req_rx_active,
   output logic [1:0]            req_rx_sbs_valid,
   output logic [1:0]            req_rx_data_valid,
   output logic [1:0]            req_rx_done,
   output logic                  tx_grant,
   output logic                  tx_command_valid,
   output logic [CMD_BITS-1:0]   tx_command,
   output logic [IO_BITS-1:0]    tx_data,
   input  logic                  tx_command_started,
   input  logic                  tx_active,
   input  logic                  tx_data_next,
   input  logic                  tx_done,
   input  logic                  rx_started,
   input  logic                  rx_active,
   input  logic                  rx_sbs_valid,
   input  logic                  rx_data_valid,
   input  logic                  rx_done,
   output logic [3:0]            outstanding,
   output logic                  full,
   output logic                  rx_orphan
);

   logic grant_q, grant_d;
   logic orphan_q, orphan_d;
   logic sc_wants, grant;
   logic push, fifo_head, fifo_empty, fifo_full;

   assign sc_wants = req_valid[REQ_SC] | sc_reserve;

   // Between transactions the scheduler wins with zero latency; once the
   // channel is busy the registered owner is held until tx_active drops.
   assign grant   = tx_active ? grant_q : sc_wants;
   assign grant_d = tx_active ? grant_q : sc_wants;

   assign tx_grant         = grant;
   assign tx_command_valid = req_valid[grant] & ~fifo_full;
   assign tx_command       = grant ? req_cmd[2*CMD_BITS-1:CMD_BITS] : req_cmd[CMD_BITS-1:0];
   assign tx_data          = grant ? req_data[2*IO_BITS-1:IO_BITS]  : req_data[IO_BITS-1:0];

   assign req_started   = route(grant, tx_command_started);
   assign req_tx_active = route(grant, tx_active);
   assign req_data_next = route(grant, tx_data_next);
   assign req_tx_done   = route(grant, tx_done);

   // Only reads that the issuer wants answered occupy a queue slot.
   assign push = tx_command_started & (tx_command == READ_CMD) & req_reply_wanted[grant];

   owner_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (rx_done),
      .din   (grant),
      .head  (fifo_head),
      .count (outstanding),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign full = fifo_full;

   assign req_rx_started    = route(fifo_head, rx_started    & ~fifo_empty);
   assign req_rx_active     = route(fifo_head, rx_active     & ~fifo_empty);
   assign req_rx_sbs_valid  = route(fifo_head, rx_sbs_valid  & ~fifo_empty);
   assign req_rx_data_valid = route(fifo_head, rx_data_valid & ~fifo_empty);
   assign req_rx_done       = route(fifo_head, rx_done       & ~fifo_empty);

   // Sticky error: RX traffic with nobody waiting, or a tag dropped on overflow.
   always_comb begin
      orphan_d = orphan_q;
      if ((rx_started | rx_done) & fifo_empty)   orphan_d = 1'b1;
      if (push & fifo_full & ~rx_done)            orphan_d = 1'b1;
   end

   assign rx_orphan = orphan_q;

   // Grant and error flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q  <= 1'b0;
         orphan_q <= 1'b0;
      end else begin
         grant_q  <= grant_d;
         orphan_q <= orphan_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for grant/mux
// behaviour and hand-written sequences for the multi-cycle cases.
module tb_mem_port_arbiter;

   localparam logic [3:0] RD = 4'h1;
   localparam logic [3:0] WR = 4'h2;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_valid;
   logic [7:0] req_cmd;
   logic [3:0] req_data;
   logic [1:0] req_reply_wanted;
   logic       sc_reserve;
   logic [1:0] req_started, req_tx_active, req_data_next, req_tx_done;
   logic [1:0] req_rx_started, req_rx_active, req_rx_sbs_valid, req_rx_data_valid, req_rx_done;
   logic       tx_grant, tx_command_valid;
   logic [3:0] tx_command;
   logic [1:0] tx_data;
   logic       tx_command_started, tx_active, tx_data_next, tx_done;
   logic       rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done;
   logic [3:0] outstanding;
   logic       full, rx_orphan;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
      .req_data(req_data), .req_reply_wanted(req_reply_wanted), .sc_reserve(sc_reserve),
      .req_started(req_started), .req_tx_active(req_tx_active),
      .req_data_next(req_data_next), .req_tx_done(req_tx_done),
      .req_rx_started(req_rx_started), .req_rx_active(req_rx_active),
      .req_rx_sbs_valid(req_rx_sbs_valid), .req_rx_data_valid(req_rx_data_valid),
      .req_rx_done(req_rx_done), .tx_grant(tx_grant), .tx_command_valid(tx_command_valid),
      .tx_command(tx_command), .tx_data(tx_data),
      .tx_command_started(tx_command_started), .tx_active(tx_active),
      .tx_data_next(tx_data_next), .tx_done(tx_done),
      .rx_started(rx_started), .rx_active(rx_active), .rx_sbs_valid(rx_sbs_valid),
      .rx_data_valid(rx_data_valid), .rx_done(rx_done),
      .outstanding(outstanding), .full(full), .rx_orphan(rx_orphan)
   );

   typedef struct {
      logic [1:0] valid;
      logic       reserve;
      logic       started;
      logic [3:0] pf_cmd;
      logic [3:0] sc_cmd;
      logic [1:0] pf_data;
      logic [1:0] sc_data;
      logic       exp_grant;
      logic       exp_cv;
      logic [3:0] exp_cmd;
      logic [1:0] exp_data;
      logic [1:0] exp_started;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 2'b00; req_cmd = 8'h00; req_data = 4'h0; req_reply_wanted = 2'b00;
      sc_reserve = 1'b0; tx_command_started = 1'b0; tx_active = 1'b0;
      tx_data_next = 1'b0; tx_done = 1'b0; rx_started = 1'b0; rx_active = 1'b0;
      rx_sbs_valid = 1'b0; rx_data_valid = 1'b0; rx_done = 1'b0;
   endtask

   // One-cycle READ start from requester idx with a reply wanted.
   task automatic issue_read(input logic idx);
      req_valid          = idx ? 2'b10 : 2'b01;
      req_cmd            = {RD, RD};
      req_reply_wanted   = 2'b11;
      tx_command_started = 1'b1;
      #1;
      chk("issue_grant", 32'(tx_grant), 32'(idx));
      cyc();
      req_valid          = 2'b00;
      tx_command_started = 1'b0;
      req_reply_wanted   = 2'b00;
   endtask

   // Reply completes; checks which requester sees the strobes.
   task automatic reply(input logic [1:0] exp_owner);
      rx_active = 1'b1; rx_data_valid = 1'b1; rx_done = 1'b1;
      #1;
      chk("rx_done_route",   32'(req_rx_done),       32'(exp_owner));
      chk("rx_data_route",   32'(req_rx_data_valid), 32'(exp_owner));
      cyc();
      rx_active = 1'b0; rx_data_valid = 1'b0; rx_done = 1'b0;
   endtask

   initial begin
      vecs[0] = '{2'b00, 1'b0, 1'b0, WR,    4'h4, 2'd1, 2'd2, 1'b0, 1'b0, WR,    2'd1, 2'b00};
      vecs[1] = '{2'b01, 1'b0, 1'b1, WR,    4'h4, 2'd1, 2'd2, 1'b0, 1'b1, WR,    2'd1, 2'b01};
      vecs[2] = '{2'b10, 1'b0, 1'b1, WR,    4'h4, 2'd1, 2'd2, 1'b1, 1'b1, 4'h4,  2'd2, 2'b10};
      vecs[3] = '{2'b11, 1'b0, 1'b1, WR,    4'h4, 2'd1, 2'd2, 1'b1, 1'b1, 4'h4,  2'd2, 2'b10};
      vecs[4] = '{2'b01, 1'b1, 1'b0, WR,    4'h4, 2'd3, 2'd0, 1'b1, 1'b0, 4'h4,  2'd0, 2'b00};
      vecs[5] = '{2'b11, 1'b1, 1'b1, 4'h6,  4'h8, 2'd0, 2'd3, 1'b1, 1'b1, 4'h8,  2'd3, 2'b10};

      idle_inputs();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      #1;
      chk("rst_grant",       32'(tx_grant),    32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_orphan",      32'(rx_orphan),   32'd0);
      chk("rst_full",        32'(full),        32'd0);
      chk("rst_cmd_valid",   32'(tx_command_valid), 32'd0);

      // Grant and command mux with the channel idle.
      for (int i = 0; i < 6; i++) begin
         req_valid          = vecs[i].valid;
         sc_reserve         = vecs[i].reserve;
         tx_command_started = vecs[i].started;
         req_cmd            = {vecs[i].sc_cmd, vecs[i].pf_cmd};
         req_data           = {vecs[i].sc_data, vecs[i].pf_data};
         #1;
         chk($sformatf("v%0d_grant", i),   32'(tx_grant),         32'(vecs[i].exp_grant));
         chk($sformatf("v%0d_cv", i),      32'(tx_command_valid), 32'(vecs[i].exp_cv));
         chk($sformatf("v%0d_cmd", i),     32'(tx_command),       32'(vecs[i].exp_cmd));
         chk($sformatf("v%0d_data", i),    32'(tx_data),          32'(vecs[i].exp_data));
         chk($sformatf("v%0d_started", i), 32'(req_started),      32'(vecs[i].exp_started));
         cyc();
      end
      idle_inputs();
      #1;
      chk("tbl_outstanding", 32'(outstanding), 32'd0);

      // Prefetcher READ holds the channel while the scheduler asks.
      req_valid = 2'b01; req_cmd = {WR, RD}; req_reply_wanted = 2'b01;
      tx_command_started = 1'b1;
      #1;
      chk("hold_start_grant", 32'(tx_grant), 32'd0);
      cyc();
      tx_command_started = 1'b0; tx_active = 1'b1; tx_data_next = 1'b1;
      req_valid = 2'b11;
      #1;
      chk("hold_grant0",     32'(tx_grant),      32'd0);
      chk("hold_data_next",  32'(req_data_next), 32'b01);
      chk("hold_tx_active",  32'(req_tx_active), 32'b01);
      chk("hold_out1",       32'(outstanding),   32'd1);
      cyc(); cyc();
      tx_data_next = 1'b0; tx_done = 1'b1;
      #1;
      chk("hold_grant1",     32'(tx_grant),    32'd0);
      chk("hold_tx_done",    32'(req_tx_done), 32'b01);
      cyc();
      tx_done = 1'b0; tx_active = 1'b0;
      #1;
      chk("release_grant",   32'(tx_grant),  32'd1);
      chk("release_cmd",     32'(tx_command), 32'(WR));
      req_valid = 2'b00;
      rx_started = 1'b1;
      #1;
      chk("hold_rx_started", 32'(req_rx_started), 32'b01);
      cyc();
      rx_started = 1'b0;
      reply(2'b01);
      chk("hold_drained",    32'(outstanding), 32'd0);

      // Replies come back in issue order.
      issue_read(1'b0);
      issue_read(1'b1);
      issue_read(1'b0);
      chk("order_out3", 32'(outstanding), 32'd3);
      reply(2'b01);
      reply(2'b10);
      reply(2'b01);
      chk("order_out0",    32'(outstanding), 32'd0);
      chk("order_orphan0", 32'(rx_orphan),   32'd0);

      // Fill the queue, then start-with-pop and start-without-pop.
      for (int i = 0; i < 7; i++) issue_read(1'b0);
      chk("full_out7", 32'(outstanding), 32'd7);
      chk("full_flag", 32'(full),        32'd1);
      req_valid = 2'b01; req_cmd = {WR, RD}; req_reply_wanted = 2'b01;
      #1;
      chk("full_cv_masked", 32'(tx_command_valid), 32'd0);
      tx_command_started = 1'b1; rx_done = 1'b1;
      cyc();
      tx_command_started = 1'b0; rx_done = 1'b0;
      #1;
      chk("full_swap_out7",   32'(outstanding), 32'd7);
      chk("full_swap_orphan", 32'(rx_orphan),   32'd0);
      tx_command_started = 1'b1;
      cyc();
      tx_command_started = 1'b0;
      #1;
      chk("overflow_out7",   32'(outstanding), 32'd7);
      chk("overflow_orphan", 32'(rx_orphan),   32'd1);
      idle_inputs();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("rst2_out",    32'(outstanding), 32'd0);
      chk("rst2_orphan", 32'(rx_orphan),   32'd0);

      // Non-replying commands occupy nothing; reservation without valid.
      req_valid = 2'b10; req_cmd = {WR, WR}; req_reply_wanted = 2'b11;
      tx_command_started = 1'b1;
      cyc();
      req_cmd = {RD, RD}; req_reply_wanted = 2'b00;
      cyc();
      tx_command_started = 1'b0;
      #1;
      chk("nonread_out0", 32'(outstanding), 32'd0);
      req_valid = 2'b00; sc_reserve = 1'b1;
      #1;
      chk("reserve_grant", 32'(tx_grant),         32'd1);
      chk("reserve_cv",    32'(tx_command_valid), 32'd0);
      sc_reserve = 1'b0;

      // RX on an empty queue.
      rx_started = 1'b1;
      #1;
      chk("orphan_gated", 32'(req_rx_started), 32'b00);
      cyc();
      rx_started = 1'b0;
      cyc(); cyc();
      chk("orphan_sticky", 32'(rx_orphan), 32'd1);

      // Reset in the middle of a scheduler read transaction.
      issue_read(1'b1);
      tx_active = 1'b1;
      #1;
      chk("mid_grant1", 32'(tx_grant), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("mid_rst_grant",  32'(tx_grant),    32'd0);
      chk("mid_rst_out",    32'(outstanding), 32'd0);
      chk("mid_rst_orphan", 32'(rx_orphan),   32'd0);
      idle_inputs();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single serial memory_interface between two requesters: index 0 is the prefetcher, index 1 is the scheduler/decoder.
- Arbitrates the TX channel and holds the grant for the whole transaction.
- Tracks outstanding read transactions in an ordered owner-tag queue.
- Routes RX strobes to the requester that issued the matching read.
- Sits between prefetcher/decoder and memory_interface inside the CPU top level, replacing the inline muxing there.

Parameters:
IO_BITS, 2, width of tx/rx data per cycle
CMD_BITS, `TX_CMD_BITS, width of a TX command header
READ_CMD, `TX_HEADER_READ_16, the only header that produces an RX reply
MAX_OUTSTANDING, 7, depth of the owner-tag queue (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-requester command valid
req_cmd  in  2*CMD_BITS  per-requester command; requester i occupies bits [i*CMD_BITS +: CMD_BITS]
req_data  in  2*IO_BITS  per-requester TX payload, same packing
req_reply_wanted  in  2  requester expects a reply to this READ
sc_reserve  in  1  scheduler claims the TX channel for its next command
req_started  out  2  tx_command_started, gated to the owner
req_tx_active  out  2  tx_active, gated to the owner
req_data_next  out  2  tx_data_next, gated to the owner
req_tx_done  out  2  tx_done, gated to the owner
req_rx_started  out  2  rx_started, gated to the RX owner
req_rx_active  out  2  rx_active, gated to the RX owner
req_rx_sbs_valid  out  2  rx_sbs_valid, gated to the RX owner
req_rx_data_valid  out  2  rx_data_valid, gated to the RX owner
req_rx_done  out  2  rx_done, gated to the RX owner
tx_grant  out  1  current TX owner (0 = prefetcher, 1 = scheduler)
tx_command_valid  out  1  command valid to memory_interface
tx_command  out  CMD_BITS  command to memory_interface
tx_data  out  IO_BITS  payload to memory_interface
tx_command_started, tx_active, tx_data_next, tx_done  in  1 each  from memory_interface
rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done  in  1 each  from memory_interface
outstanding  out  4  number of queued read replies
full  out  1  outstanding == MAX_OUTSTANDING
rx_orphan  out  1  sticky error flag

Behaviour:
- Reset: grant_q=0, queue empty, outstanding=0, rx_orphan=0. All gated outputs are 0 because the inputs are gated.
- sc_wants = req_valid[1] | sc_reserve.
- Grant selection:
  - While !tx_active: grant_q <= sc_wants every cycle, and effective grant = sc_wants (combinational, zero latency). The scheduler wins over the prefetcher.
  - While tx_active: effective grant = grant_q, held until the transaction ends.
- tx_command_valid = req_valid[grant] & !full. tx_command and tx_data mux from the granted slice.
- TX strobes are routed only to the granted index; the other index reads 0.
- Push condition: tx_command_started & tx_command == READ_CMD & req_reply_wanted[grant]. It pushes tag = grant. Writes, and reads without reply_wanted, push nothing.
- RX owner = tag at the queue head. All rx_* strobes are routed to that index only.
- Pop on rx_done.
- If the queue is empty, all req_rx_* read 0. Any rx_started or rx_done while empty sets rx_orphan, which stays set until reset.
- Push and pop in the same cycle: outstanding is unchanged and the tags stay in order. A pop with the queue empty is ignored.
- Push while full cannot happen, since valid is masked. If it occurs anyway, drop the tag and set rx_orphan.
- Queue is a circular buffer with read/write pointers wrapping modulo MAX_OUTSTANDING.
- Reset mid-transaction: queue cleared and grant returns to 0 next cycle. The external memory_interface is reset by the same signal.
- sc_reserve is asserted with no valid: the prefetcher is starved. Intended, since it guarantees a read-modify-write keeps the channel.

Decomposition:
- Requester index constants REQ_PF=0 and REQ_SC=1 go in the shared header alongside the TX_* command constants.
- One sub-module: owner_tag_fifo (1-bit entries, DEPTH=MAX_OUTSTANDING; ports push, pop, din, head, count, empty, full).

Test Plan:
- Both requesters valid with tx_active=0 -> tx_grant=1, scheduler command on tx_command, req_started=2'b10 on start.
- Prefetcher READ started, then sc_valid rises while tx_active=1 -> grant stays 0 until tx_active falls, then grant=1.
- Reads issued pf, sc, pf (all reply_wanted) -> outstanding=3; rx_done sequence routes req_rx_done=01, 10, 01; outstanding returns to 0.
- Issue 7 reads with no replies -> full=1, tx_command_valid=0 despite req_valid=1; rx_done in the same cycle as a start keeps outstanding=7.
- Scheduler write (non-READ) started -> outstanding unchanged; sc_reserve=1 with req_valid[1]=0 -> grant=1 and tx_command_valid=0.
- rx_started with the queue empty -> rx_orphan=1 and stays 1; reset -> rx_orphan=0, outstanding=0, tx_grant=0.
